sparc_mem_ctrl: RTL

SPARC_MEM_CTRL -- requirements
Module: sparc_mem_ctrl

---
 rtl/sparc_mem_pkg.sv | 36 +++
 rtl/sparc_byte_ram.sv | 39 +++
 rtl/sparc_mem_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/sparc_mem_pkg.sv
// sparc_mem_pkg: shared encodings for the SPARC-style byte-addressed memory
// controller.
//   - Type encodings (byte / halfword / word / illegal)
//   - ReadWrite encodings (1 = read, 0 = write)
//   - Controller FSM state enum
//   - lane_mask(): byte lanes touched by an access of a given Type
package sparc_mem_pkg;

    localparam logic [1:0] TYPE_BYTE    = 2'b00;
    localparam logic [1:0] TYPE_HALF    = 2'b01;
    localparam logic [1:0] TYPE_WORD    = 2'b10;
    localparam logic [1:0] TYPE_ILLEGAL = 2'b11;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Lane 0 is always the byte at the access address; higher lanes follow
    // at Address+1, +2, +3 (wrapped by the RAM).
    function automatic logic [3:0] lane_mask(input logic [1:0] t);
        logic [3:0] m;
        case (t)
            TYPE_BYTE: m = 4'b0001;
            TYPE_HALF: m = 4'b0011;
            TYPE_WORD: m = 4'b1111;
            default:   m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sparc_byte_ram.sv
// sparc_byte_ram: DEPTH-byte storage with four byte lanes.
// Lane k addresses byte (addr_i + k) mod DEPTH, so multi-byte accesses wrap
// at the top of storage. Writes are per-lane on the rising clock edge;
// reads of all four lanes are combinational. Contents are never reset.
// Ports:
//   clk_i    - clock
//   we_i     - per-lane write enable
//   addr_i   - base byte address (lane 0)
//   wdata_i  - lane k write data in bits [8k+7:8k]
//   rdata_o  - lane k read data in bits [8k+7:8k]
module sparc_byte_ram #(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512
) (
    input  logic              clk_i,
    input  logic [3:0]        we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]       mem_q [DEPTH];
    logic [IDX_W-1:0] idx   [4];

    for (genvar k = 0; k < 4; k++) begin : g_lane
        // Modulo by DEPTH (not 2**ADDR_W) so non-power-of-two sizes wrap too.
        assign idx[k] = IDX_W'((32'(addr_i) + 32'(k)) % 32'(DEPTH));
        assign rdata_o[8*k +: 8] = mem_q[idx[k]];

        always_ff @(posedge clk_i) begin
            if (we_i[k]) begin
                mem_q[idx[k]] <= wdata_i[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/sparc_mem_ctrl.sv
// sparc_mem_ctrl: SPARC-style memory controller with fixed access latency.
// An accepted request (Mov in IDLE) is latched, waits WAIT_CYCLES cycles,
// then completes with a one-cycle MFC pulse. Data is big-endian: the byte at
// Address is the most significant byte of the access.
// Optional feature macro: SPARC_MEM_MISALIGN_TRAP_EN -- misaligned halfword
// or word accesses perform no access and report Err with MFC.
// Ports:
//   Clk        - clock (rising edge)
//   Clr        - asynchronous active-low reset
//   Mov        - request strobe (accepted only in IDLE)
//   ReadWrite  - 1 read, 0 write
//   Type       - 00 byte, 01 halfword, 10 word, 11 illegal
//   Sign       - 1 sign-extend, 0 zero-extend reads
//   Address    - byte address
//   DataIn     - right-justified write data
//   DataOut    - right-justified, extended read data (held between reads)
//   MFC        - completion pulse
//   Busy       - request in flight (through MFC)
//   Err        - error qualifier, valid with MFC
// Handshake: a request is taken on the rising edge where Mov=1 and Busy=0;
// exactly one MFC follows WAIT_CYCLES+1 cycles after that accept cycle, and
// Mov is ignored until the cycle after MFC.
module sparc_mem_ctrl
    import sparc_mem_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              Mov,
    input  logic              ReadWrite,
    input  logic [1:0]        Type,
    input  logic              Sign,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MFC,
    output logic              Busy,
    output logic              Err
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rw_q, rw_d;
    logic [1:0]        type_q, type_d;
    logic              sign_q, sign_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       din_q, din_d;
    logic [31:0]       dout_q, dout_d;

    logic              accept;
    logic              commit;
    logic              cur_rw, cur_sign, cur_err, misaligned;
    logic [1:0]        cur_type;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_din;
    logic [31:0]       wlanes, rlanes, rd_ext;
    logic [3:0]        we;

    assign accept = (state_q == ST_IDLE) && Mov;

    // With WAIT_CYCLES=0 the commit edge is the accept edge itself, so the
    // access works from the live inputs in IDLE and from the latch otherwise.
    assign cur_rw   = (state_q == ST_IDLE) ? ReadWrite : rw_q;
    assign cur_type = (state_q == ST_IDLE) ? Type      : type_q;
    assign cur_sign = (state_q == ST_IDLE) ? Sign      : sign_q;
    assign cur_addr = (state_q == ST_IDLE) ? Address   : addr_q;
    assign cur_din  = (state_q == ST_IDLE) ? DataIn    : din_q;

`ifdef SPARC_MEM_MISALIGN_TRAP_EN
    assign misaligned = ((cur_type == TYPE_HALF) && cur_addr[0]) ||
                        ((cur_type == TYPE_WORD) && (cur_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign cur_err = (cur_type == TYPE_ILLEGAL) || misaligned;

    // Next-state / counter / request latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = accept ? ReadWrite : rw_q;
        type_d  = accept ? Type      : type_q;
        sign_d  = accept ? Sign      : sign_q;
        addr_d  = accept ? Address   : addr_q;
        din_d   = accept ? DataIn    : din_q;
        case (state_q)
            ST_IDLE: begin
                if (Mov) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Gating with Clr keeps a reset that coincides with the commit edge from
    // writing storage (the RAM itself has no reset).
    assign commit = Clr && (state_q != ST_DONE) && (state_d == ST_DONE);

    // Big-endian lane packing: lane 0 (byte at Address) carries the MSB.
    always_comb begin
        case (cur_type)
            TYPE_BYTE: wlanes = {24'h0, cur_din[7:0]};
            TYPE_HALF: wlanes = {16'h0, cur_din[7:0], cur_din[15:8]};
            TYPE_WORD: wlanes = {cur_din[7:0], cur_din[15:8], cur_din[23:16], cur_din[31:24]};
            default:   wlanes = 32'h0;
        endcase
    end

    assign we = (commit && (cur_rw == RW_WRITE) && !cur_err) ? lane_mask(cur_type) : 4'b0000;

    always_comb begin
        case (cur_type)
            TYPE_BYTE: rd_ext = {{24{cur_sign & rlanes[7]}}, rlanes[7:0]};
            TYPE_HALF: rd_ext = {{16{cur_sign & rlanes[7]}}, rlanes[7:0], rlanes[15:8]};
            TYPE_WORD: rd_ext = {rlanes[7:0], rlanes[15:8], rlanes[23:16], rlanes[31:24]};
            default:   rd_ext = dout_q;
        endcase
    end

    assign dout_d = (commit && (cur_rw == RW_READ) && !cur_err) ? rd_ext : dout_q;

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            type_q  <= 2'b00;
            sign_q  <= 1'b0;
            addr_q  <= '0;
            din_q   <= 32'h0;
            dout_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            type_q  <= type_d;
            sign_q  <= sign_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
        end
    end

    sparc_byte_ram #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk_i   (Clk),
        .we_i    (we),
        .addr_i  (cur_addr),
        .wdata_i (wlanes),
        .rdata_o (rlanes)
    );

    assign DataOut = dout_q;
    assign MFC     = (state_q == ST_DONE);
    assign Busy    = (state_q != ST_IDLE);
    assign Err     = MFC && cur_err;

endmodule
